// File: rtl/uart_cmd_pkg.sv
// uart_cmd_pkg: FSM states and default command characters shared by the UART command controller
package uart_cmd_pkg;

    typedef enum logic [1:0] {IDLE, POP, EXEC, ACK} state_t;

    localparam logic [7:0] CODE_R   = "R";
    localparam logic [7:0] CODE_C   = "C";
    localparam logic [7:0] CODE_M   = "M";
    localparam logic [7:0] NAK_CHAR = "?";

endpackage

// File: rtl/cmd_match.sv
// cmd_match: compares a command byte against every channel code and selects the lowest matching channel
module cmd_match #(
    parameter int                           NUM_CH     = 3,
    parameter int                           DATA_WIDTH = 8,
    parameter logic [NUM_CH*DATA_WIDTH-1:0] CMD_CODES  = '0
) (
    input  logic [DATA_WIDTH-1:0] cmd,
    output logic                  hit,
    output logic [NUM_CH-1:0]     sel
);

    logic [NUM_CH-1:0] match;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_cmp
        assign match[i] = cmd == CMD_CODES[i*DATA_WIDTH +: DATA_WIDTH];
    end

    // Keep only the lowest set bit so duplicate codes drive a single channel
    always_comb begin
        hit = |match;
        sel = match & (-match);
    end

endmodule

// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl: pops command bytes from an RX FIFO, drives control channels and echoes/NAKs to a TX FIFO
module uart_cmd_ctrl
    import uart_cmd_pkg::*;
#(
    parameter int                           NUM_CH      = 3,
    parameter int                           DATA_WIDTH  = 8,
    parameter logic [NUM_CH*DATA_WIDTH-1:0] CMD_CODES   = {CODE_M, CODE_C, CODE_R},
    parameter logic [NUM_CH-1:0]            TOGGLE_MASK = 3'b001,
    parameter bit                           ACK_EN      = 1'b1,
    parameter logic [DATA_WIDTH-1:0]        NAK_CODE    = NAK_CHAR
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_CH-1:0]     btn,
    input  logic [DATA_WIDTH-1:0] rx_data,
    input  logic                  rx_empty,
    output logic                  rx_rd,
    input  logic                  tx_full,
    output logic                  tx_wr,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic [NUM_CH-1:0]     ch_out,
    output logic [7:0]            err_cnt
);

    state_t                state;
    logic [DATA_WIDTH-1:0] cmd_reg;
    logic                  hit;
    logic [NUM_CH-1:0]     sel;
    logic [NUM_CH-1:0]     act;

    cmd_match #(
        .NUM_CH     (NUM_CH),
        .DATA_WIDTH (DATA_WIDTH),
        .CMD_CODES  (CMD_CODES)
    ) u_match (
        .cmd (cmd_reg),
        .hit (hit),
        .sel (sel)
    );

    // Buttons and a UART hit on the same channel merge into a single action
    always_comb begin
        act = btn | ((state == EXEC && hit) ? sel : '0);
    end

    // Command FSM with registered FIFO strobes, channel outputs and error counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cmd_reg <= '0;
            rx_rd   <= 1'b0;
            tx_wr   <= 1'b0;
            tx_data <= '0;
            ch_out  <= '0;
            err_cnt <= '0;
        end else begin
            rx_rd  <= 1'b0;
            tx_wr  <= 1'b0;
            ch_out <= (TOGGLE_MASK & (ch_out ^ act)) | (~TOGGLE_MASK & act);
            case (state)
                IDLE: begin
                    if (!rx_empty) begin
                        rx_rd <= 1'b1;
                        state <= POP;
                    end
                end
                POP: begin
                    cmd_reg <= rx_data;
                    state   <= EXEC;
                end
                EXEC: begin
                    if (!hit && err_cnt != 8'hff) err_cnt <= err_cnt + 8'd1;
                    tx_data <= hit ? cmd_reg : NAK_CODE;
                    state   <= ACK_EN ? ACK : IDLE;
                end
                ACK: begin
                    if (!tx_full) begin
                        tx_wr <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// tb_uart_cmd_ctrl: randomized and directed stimulus checked against a transaction-timed reference model
module tb_uart_cmd_ctrl;

    localparam logic [2:0] TM = 3'b001;
    localparam logic [7:0] CODES [3] = '{"R", "C", "M"};

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] btn;
    logic [7:0] rx_data;
    logic       rx_empty;
    logic       rx_rd;
    logic       tx_full;
    logic       tx_wr;
    logic [7:0] tx_data;
    logic [2:0] ch_out;
    logic [7:0] err_cnt;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [7:0] q [$];
    logic [7:0] all_b [$];
    int         popped = 0;
    logic       pop_flag = 1'b0;

    int         mi = 0;
    int         ready = 0;
    int         ack_from = 0;
    bit         ack_pend = 0;
    logic [7:0] ack_byte = 8'h0;
    logic       exp_rd = 1'b0;
    logic       exp_wr = 1'b0;
    logic [7:0] exp_txd = 8'h0;
    logic [2:0] exp_ch = 3'b0;
    logic [7:0] exp_err = 8'h0;
    logic [2:0] ev_act [int];
    bit         ev_miss [int];
    logic [2:0] act;
    logic [7:0] b;
    int         idx;

    uart_cmd_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .btn      (btn),
        .rx_data  (rx_data),
        .rx_empty (rx_empty),
        .rx_rd    (rx_rd),
        .tx_full  (tx_full),
        .tx_wr    (tx_wr),
        .tx_data  (tx_data),
        .ch_out   (ch_out),
        .err_cnt  (err_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic int lookup(input logic [7:0] v);
        lookup = -1;
        for (int i = 2; i >= 0; i--) if (CODES[i] == v) lookup = i;
    endfunction

    task automatic refresh();
        rx_empty = q.size() == 0;
        rx_data  = rx_empty ? 8'h0 : q[0];
    endtask

    task automatic push(input logic [7:0] v);
        q.push_back(v);
        all_b.push_back(v);
        refresh();
    endtask

    task automatic tick(input logic [2:0] bv, input logic fv);
        @(posedge clk);
        #2;
        if (pop_flag) begin
            void'(q.pop_front());
            popped++;
        end
        btn = bv;
        tx_full = fv && !(tx_wr && !tx_full);
        refresh();
    endtask

    // Reference model: each accepted byte is popped the cycle after it is seen in idle,
    // acts two cycles later, then owns the TX side until the FIFO has room
    always @(negedge clk) begin
        if (!reset) begin
            chk("rst_rx_rd", rx_rd, 0);
            chk("rst_tx_wr", tx_wr, 0);
            chk("rst_ch_out", ch_out, 0);
            chk("rst_err_cnt", err_cnt, 0);
            exp_rd = 0; exp_wr = 0; exp_ch = 0; exp_err = 0;
            ack_pend = 0; ready = 0; pop_flag = 0; mi = popped;
            ev_act.delete();
            ev_miss.delete();
        end else begin
            chk("rx_rd", rx_rd, exp_rd);
            chk("tx_wr", tx_wr, exp_wr);
            chk("ch_out", ch_out, exp_ch);
            chk("err_cnt", err_cnt, exp_err);
            if (exp_wr) chk("tx_data", tx_data, exp_txd);
            chk("rd_when_empty", rx_rd && rx_empty, 0);
            chk("wr_when_full", tx_wr && tx_full, 0);
            pop_flag = rx_rd;
            exp_rd = 0;
            exp_wr = 0;
            if (ack_pend) begin
                if (cyc >= ack_from && !tx_full) begin
                    exp_wr = 1; exp_txd = ack_byte; ack_pend = 0; ready = cyc + 1;
                end
            end else if (cyc >= ready && mi < all_b.size()) begin
                b = all_b[mi];
                mi++;
                exp_rd = 1;
                idx = lookup(b);
                if (idx >= 0) ev_act[cyc+3] = 3'(1 << idx);
                else ev_miss[cyc+3] = 1;
                ack_byte = (idx >= 0) ? b : "?";
                ack_from = cyc + 3;
                ack_pend = 1;
            end
            act = btn | (ev_act.exists(cyc + 1) ? ev_act[cyc+1] : 3'b0);
            exp_ch = (TM & (exp_ch ^ act)) | (~TM & act);
            if (ev_miss.exists(cyc + 1) && exp_err != 8'hff) exp_err++;
        end
    end

    initial begin
        logic [7:0] v;
        int r;
        btn = 0; tx_full = 0; reset = 1; rx_empty = 1; rx_data = 0;
        #1 reset = 0;
        repeat (3) tick(0, 0);
        reset = 1;
        tick(0, 0);
        push("R");
        repeat (8) tick(0, 0);
        chk("r_level", ch_out[0], 1);
        push("C");
        repeat (8) tick(0, 0);
        chk("c_pulse_done", ch_out[1], 0);
        push("x");
        repeat (8) tick(0, 0);
        chk("err_one", err_cnt, 1);
        tick(0, 1);
        push("M");
        push("R");
        repeat (13) tick(0, 1);
        repeat (12) tick(0, 0);
        push("R");
        tick(0, 0);
        tick(3'b001, 0);
        repeat (6) tick(0, 0);
        push("R");
        repeat (5) tick(0, 1);
        reset = 0;
        #1;
        chk("async_rx_rd", rx_rd, 0);
        chk("async_tx_wr", tx_wr, 0);
        chk("async_tx_data", tx_data, 0);
        chk("async_ch_out", ch_out, 0);
        chk("async_err_cnt", err_cnt, 0);
        repeat (3) tick(0, 0);
        reset = 1;
        repeat (10) tick(0, 0);
        for (int i = 0; i < 300; i++) begin
            v = 8'($urandom_range(0, 255));
            if (lookup(v) >= 0) v = "x";
            push(v);
        end
        for (int i = 0; i < 1500 && q.size() > 0; i++) tick(0, 0);
        repeat (6) tick(0, 0);
        chk("bad_drain", q.size(), 0);
        chk("err_sat", err_cnt, 255);
        repeat (3000) begin
            tick(($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'b0,
                 $urandom_range(0, 4) == 0);
            if (q.size() < 4 && $urandom_range(0, 3) == 0) begin
                r = $urandom_range(0, 5);
                v = (r < 3) ? CODES[r] : (r == 3) ? 8'h78 : (r == 4) ? 8'h3f : 8'($urandom_range(0, 255));
                push(v);
            end
        end
        for (int i = 0; i < 100 && q.size() > 0; i++) tick(0, 0);
        repeat (8) tick(0, 0);
        chk("final_drain", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_cmd_ctrl.md
UART_CMD_CTRL -- requirements
Module: uart_cmd_ctrl

Interface
REQ-001 Parameter NUM_CH, default 3: number of control channels.
REQ-002 Parameter DATA_WIDTH, default 8: command byte width.
REQ-003 Parameter CMD_CODES, default {"M","C","R"} packed, DATA_WIDTH bits per channel: channel i code at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-004 Parameter TOGGLE_MASK, default 3'b001: bit i=1 makes channel i a level toggle; bit i=0 makes it a one-cycle pulse.
REQ-005 Parameter ACK_EN, default 1: 1 enables echo/NAK bytes to the TX FIFO.
REQ-006 Parameter NAK_CODE, default "?": byte returned for an unrecognised command.
REQ-007 One clock; reset is asynchronous and active-low.
REQ-008 clk  input  1  system clock.
REQ-009 reset  input  1  asynchronous, active-low reset.
REQ-010 btn  input  NUM_CH  debounced single-cycle button pulses, one per channel.
REQ-011 rx_data  input  DATA_WIDTH  RX FIFO head; valid whenever rx_empty=0 (show-ahead).
REQ-012 rx_empty  input  1  RX FIFO empty.
REQ-013 rx_rd  output  1  RX FIFO pop strobe.
REQ-014 tx_full  input  1  TX FIFO full.
REQ-015 tx_wr  output  1  TX FIFO push strobe.
REQ-016 tx_data  output  DATA_WIDTH  byte pushed to the TX FIFO.
REQ-017 ch_out  output  NUM_CH  per-channel control: level for toggle channels, pulse for pulse channels.
REQ-018 err_cnt  output  8  count of unrecognised commands, saturating.

Function
REQ-019 The FSM SHALL have the states IDLE, POP, EXEC and ACK.
REQ-020 IDLE: rx_empty=0 -> POP; otherwise remain in IDLE.
REQ-021 POP: rx_rd=1 for exactly this cycle; rx_data latched into cmd_reg -> EXEC.
REQ-022 EXEC: cmd_reg compared against all CMD_CODES; on a hit, channel i acts at the edge ending EXEC; then -> ACK if ACK_EN=1, else -> IDLE.
REQ-023 Duplicate codes: only the lowest matching channel index acts.
REQ-024 Channel action, toggle channel: ch_out[i] inverts; pulse channel: ch_out[i]=1 for one cycle.
REQ-025 Latency: byte present in IDLE at cycle 0 -> rx_rd high in cycle 1 -> ch_out change visible in cycle 3.
REQ-026 Miss in EXEC: err_cnt increments; err_cnt holds at 255 once reached.
REQ-027 ACK: when tx_full=0, tx_wr=1 for one cycle and tx_data=cmd_reg on a hit or NAK_CODE on a miss -> IDLE.
REQ-028 ACK with tx_full=1: remain in ACK with tx_wr=0, no RX pops, and tx_data stable.
REQ-029 btn[i] acts on channel i at the next edge in any FSM state, without an ACK.
REQ-030 A btn pulse and a UART hit on the same channel in the same cycle SHALL produce one action: one toggle, or one pulse cycle.
REQ-031 rx_rd SHALL never assert when rx_empty=1; tx_wr SHALL never assert when tx_full=1.
REQ-032 At most one byte SHALL be consumed per 3 cycles (4 with ACK); back-to-back bytes SHALL be processed in FIFO order.

Reset
REQ-033 On reset low, asynchronously: state=IDLE, ch_out=0, err_cnt=0, rx_rd=0, tx_wr=0, tx_data=0, cmd_reg=0.
REQ-034 Reset mid-ACK SHALL drop the pending ACK byte; a byte already popped and not yet executed is lost.
REQ-035 After reset release, operation SHALL resume at the first clock edge.

Structure
REQ-036 Package uart_cmd_pkg SHALL hold the state enum, the default code characters and NAK_CODE.
REQ-037 One sub-module, cmd_match, SHALL map cmd_reg and CMD_CODES to hit and a one-hot lowest-index channel select (combinational).
REQ-038 All outputs SHALL be registered.

Verification
REQ-039 Scenario: RX byte "R", tx_full=0 -> rx_rd in cycle 1, ch_out[0] goes 0->1 in cycle 3, tx_wr with tx_data="R".
REQ-040 Scenario: RX byte "C" -> ch_out[1] high for exactly 1 cycle, echo "C".
REQ-041 Scenario: RX byte "x" -> no ch_out change, err_cnt=1, tx_data="?"; 300 bad bytes -> err_cnt=255.
REQ-042 Scenario: tx_full=1 held for 10 cycles during ACK with a second byte queued -> tx_wr=0 and rx_rd=0 throughout; after release, echo, then second byte popped.
REQ-043 Scenario: btn[0] and UART "R" hitting channel 0 in the same cycle -> ch_out[0] toggles once.
REQ-044 Scenario: reset asserted during ACK -> all outputs 0 asynchronously, no tx_wr after release.
